ram_access_master: RTL and testbench

- Load/store initiator that sits between the CPU datapath and the single-port 2^16 x 32 word RAM.
- Accepts byte-addressed load/store requests of byte, halfword or word size and drives the RAM's write_enable, read_enable, address and data_input ports.
- Captures data_output after a fixed read latency and returns sign- or zero-extended load data.
- Performs sub-word stores as read-modify-write, because the RAM has no byte enables.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_lane_align.sv | 41 ++++
 rtl/ram_access_master.sv | 195 +++++++++++++++++++
 tb/tb_ram_access_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and alignment helper for the RAM load/store initiator.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Legal range of the RAM read latency; the wait counter is 3 bits wide.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_MERGE,
    ST_WR,
    ST_RESP
  } state_e;

  // Misaligned halfword/word or reserved size.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = lane[0];
      SZ_WORD: err = |lane;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: extract+extend for loads, lane insertion for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        signed_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane from the RAM word and extend it to 32 bits.
  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    case (size_i)
      SZ_BYTE: ext_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: ext_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default: ext_o = word_i;
    endcase
  end

  // Overlay the right-justified store data onto the addressed lane(s).
  always_comb begin
    merged_o = word_i;
    case (size_i)
      SZ_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/ram_access_master.sv
// Load/store initiator for a single-port word RAM without byte enables.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module ram_access_master
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              ram_write_enable,
  output logic              ram_read_enable,
  output logic [ADDR_W-1:0] ram_address,
  output logic [31:0]       ram_data_input,
  input  logic [31:0]       ram_data_output
);

  // An out-of-range latency falls back to the minimum so the wait counter never wraps.
  localparam bit RD_LAT_OK = (RD_LAT >= RD_LAT_MIN) && (RD_LAT <= RD_LAT_MAX);
  localparam int RD_LAT_EFF = RD_LAT_OK ? RD_LAT : RD_LAT_MIN;
  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT_EFF - 1);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_rdata_q, resp_rdata_d;
  logic                resp_error_q, resp_error_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_re_q, ram_re_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         ram_din_q, ram_din_d;

  // Latched request and captured read word (datapath, no reset needed).
  logic                write_q;
  logic [1:0]          size_q;
  logic                signed_q;
  logic [1:0]          lane_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdword_q;

  logic                accept;
  logic                capture;
  logic                req_err;
  logic [31:0]         align_word;
  logic [31:0]         ext_data;
  logic [31:0]         merged_data;

  assign accept     = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign req_err    = access_error(req_size, req_addr[1:0]);
  assign align_word = (state_q == ST_MERGE) ? rdword_q : ram_data_output;

  mem_lane_align u_align (
    .size_i   (size_q),
    .lane_i   (lane_q),
    .signed_i (signed_q),
    .word_i   (align_word),
    .wdata_i  (wdata_q),
    .ext_o    (ext_data),
    .merged_o (merged_data)
  );

  // Next-state and registered-output logic; strobes default low, address/data hold.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'h0;
    resp_error_d = 1'b0;
    ram_we_d     = 1'b0;
    ram_re_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_din_d    = ram_din_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d    = ST_WR;
            ram_we_d   = 1'b1;
            ram_addr_d = req_addr[ADDR_W+1:2];
            ram_din_d  = req_wdata;
          end else begin
            state_d    = ST_RD;
            ram_re_d   = 1'b1;
            ram_addr_d = req_addr[ADDR_W+1:2];
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
        cnt_d   = CNT_LOAD;
      end
      ST_RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          capture = 1'b1;
          if (write_q) begin
            state_d = ST_MERGE;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = ext_data;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_MERGE: begin
        state_d   = ST_WR;
        ram_we_d  = 1'b1;
        ram_din_d = merged_data;
      end
      ST_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Control state and outputs; reset drops any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_re_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
      ram_we_q     <= ram_we_d;
      ram_re_q     <= ram_re_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
    end
  end

  // Request fields on handshake, RAM word when the read latency expires.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_q  <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      lane_q   <= req_addr[1:0];
      wdata_q  <= req_wdata;
    end
    if (capture) begin
      rdword_q <= ram_data_output;
    end
  end

  assign req_ready        = req_ready_q;
  assign resp_valid       = resp_valid_q;
  assign resp_rdata       = resp_rdata_q;
  assign resp_error       = resp_error_q;
  assign ram_write_enable = ram_we_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_address      = ram_addr_q;
  assign ram_data_input   = ram_din_q;

endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: RAM environment model plus a spec-level reference memory.
module tb_ram_access_master;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 3;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic              ram_write_enable;
  logic              ram_read_enable;
  logic [ADDR_W-1:0] ram_address;
  logic [31:0]       ram_data_input;
  logic [31:0]       ram_data_output;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] last_rdata;

  logic [31:0] ram_mem [int];
  logic [31:0] ref_mem [int];
  logic [RD_LAT-1:0][31:0] rd_pipe;
  logic [RD_LAT-1:0]       rd_vld;

  ram_access_master #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .ram_address      (ram_address),
    .ram_data_input   (ram_data_input),
    .ram_data_output  (ram_data_output)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_get(input int k);
    return ram_mem.exists(k) ? ram_mem[k] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_get(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  // Single-port RAM: write commits on the edge, read data appears RD_LAT cycles later.
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[RD_LAT-2:0], ram_read_enable ? ram_get(int'(ram_address)) : 32'hDEADBEEF};
    rd_vld  <= {rd_vld[RD_LAT-2:0], ram_read_enable};
    if (ram_write_enable) ram_mem[int'(ram_address)] = ram_data_input;
  end
  assign ram_data_output = rd_vld[RD_LAT-1] ? rd_pipe[RD_LAT-1] : 32'hDEADBEEF;

  function automatic logic [31:0] outs_or();
    return 32'(|{req_ready, resp_valid, resp_rdata, resp_error, ram_write_enable,
                 ram_read_enable, ram_address, ram_data_input});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and check latency, response, RAM traffic against the reference.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [ADDR_W+1:0] a, input logic [31:0] wd);
    int idx, sh, exp_lat, lat, we_n, re_n, n, exp_we, exp_re;
    logic err, ready_low, done;
    logic [31:0] old, mask, exp_word, raw, exp_rdata, we_addr, we_data, re_addr;
    idx  = int'(a[ADDR_W+1:2]);
    sh   = 8 * int'(a[1:0]);
    err  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    old  = ref_get(idx);
    mask = (sz == 2'b00) ? (32'hFF << sh) : (sz == 2'b01) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
    exp_word = (old & ~mask) | ((wd << sh) & mask);
    raw = (old & mask) >> sh;
    if (sg && sz == 2'b00 && raw[7])  raw = raw | 32'hFFFF_FF00;
    if (sg && sz == 2'b01 && raw[15]) raw = raw | 32'hFFFF_0000;
    exp_rdata = (err || w) ? 32'h0 : raw;
    exp_lat = err ? 1 : (w && sz == 2'b10) ? 2 : w ? RD_LAT + 4 : RD_LAT + 2;
    exp_we  = (!err && w) ? 1 : 0;
    exp_re  = (!err && !(w && sz == 2'b10)) ? 1 : 0;

    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = 18'($urandom); req_wdata = $urandom;
    lat = 1; done = 1'b0; ready_low = 1'b1; we_n = 0; re_n = 0;
    we_addr = 32'h0; we_data = 32'h0; re_addr = 32'h0;
    while (!done && lat <= 40) begin
      if (ram_write_enable === 1'b1) begin
        we_n++; we_addr = 32'(ram_address); we_data = ram_data_input;
      end
      if (ram_read_enable === 1'b1) begin
        re_n++; re_addr = 32'(ram_address);
      end
      if (req_ready !== 1'b0) ready_low = 1'b0;
      if (resp_valid === 1'b1) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    last_rdata = resp_rdata;
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_error", 32'(resp_error), 32'(err));
    check("resp_rdata", resp_rdata, exp_rdata);
    check("write_pulses", 32'(we_n), 32'(exp_we));
    check("read_pulses", 32'(re_n), 32'(exp_re));
    check("ready_low_busy", 32'(ready_low), 32'd1);
    if (we_n == 1) begin
      check("write_address", we_addr, 32'(idx));
      check("write_data", we_data, exp_word);
    end
    if (re_n == 1) check("read_address", re_addr, 32'(idx));
    @(posedge clk);
    #1;
    check("resp_single_pulse", 32'(resp_valid), 32'd0);
    check("ready_after_resp", 32'(req_ready), 32'd1);
    if (!err && w) ref_mem[idx] = exp_word;
    check("ram_contents", ram_get(idx), ref_get(idx));
  endtask

  initial begin
    logic [ADDR_W+1:0] a;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = 32'h0; last_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs_or(), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed scenarios
    do_req(1'b1, 2'b10, 1'b0, 18'd264, 32'h0000_0014);
    do_req(1'b1, 2'b00, 1'b0, 18'd265, 32'h0000_00AB);
    check("plan_rmw_word", ram_get(66), 32'h0000_AB14);
    do_req(1'b0, 2'b00, 1'b1, 18'd265, 32'h0);
    check("plan_sbyte_load", last_rdata, 32'hFFFF_FFAB);
    do_req(1'b0, 2'b01, 1'b0, 18'd264, 32'h0);
    check("plan_uhalf_load", last_rdata, 32'h0000_AB14);
    do_req(1'b1, 2'b10, 1'b0, 18'd400, 32'h8001_0000);
    do_req(1'b0, 2'b01, 1'b1, 18'd402, 32'h0);
    check("plan_shalf_load", last_rdata, 32'hFFFF_8001);
    do_req(1'b0, 2'b10, 1'b0, 18'd266, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 18'd265, 32'h1234);
    do_req(1'b0, 2'b11, 1'b1, 18'd264, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 18'd220, 32'h0);
    do_req(1'b1, 2'b00, 1'b0, 18'h3FFFF, 32'h0000_005A);
    do_req(1'b0, 2'b10, 1'b0, 18'h3FFFC, 32'h0);
    check("plan_wrap_word", last_rdata, 32'h5A00_0000);

    // Reset while a byte store is waiting on read data
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 18'd265; req_wdata = 32'h0000_00CD;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_ready_before_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", outs_or(), 32'h0);
    repeat (RD_LAT + 4) @(posedge clk);
    #1;
    check("reset_held_outputs", outs_or(), 32'h0);
    check("reset_no_write", ram_get(66), ref_get(66));
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 18'd264, 32'h0);
    check("plan_word66_after_reset", last_rdata, 32'h0000_AB14);

    // Randomized traffic over a small window so stores and loads overlap
    for (int i = 0; i < 60; i++) begin
      a = 18'(($urandom_range(60, 71) << 2) | $urandom_range(0, 3));
      do_req(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
             1'($urandom), a, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "time limit");
  end

endmodule
